// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: buffers one ALU and one load result and feeds the
// register-file write port with one registered write per cycle, oldest first.
module regfile_wb_arb #(
    parameter bit MEM_WINS_TIE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        busy
);

    logic        alu_full, mem_full, old_mem;
    logic [4:0]  alu_rd_q, mem_rd_q;
    logic [31:0] alu_data_q, mem_data_q;

    logic grant_alu, grant_mem;
    logic alu_load, mem_load;
    logic alu_full_n, mem_full_n, old_mem_n;

    // Handshake: a beat transfers on a rising edge when valid && ready; ready
    // depends only on slot occupancy and the grant, never on valid.
    always_comb begin
        grant_alu  = alu_full && (!mem_full || !old_mem);
        grant_mem  = mem_full && (!alu_full || old_mem);
        alu_ready  = !alu_full || grant_alu;
        mem_ready  = !mem_full || grant_mem;
        // Writes to x0 are accepted but never occupy a slot.
        alu_load   = alu_valid && alu_ready && (alu_rd != 5'd0);
        mem_load   = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_full_n = alu_load || (alu_full && !grant_alu);
        mem_full_n = mem_load || (mem_full && !grant_mem);
        old_mem_n  = old_mem;
        if (alu_load && mem_load) begin
            old_mem_n = MEM_WINS_TIE;
        end else if (alu_load && mem_full_n) begin
            old_mem_n = 1'b1;
        end else if (mem_load && alu_full_n) begin
            old_mem_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_full   <= 1'b0;
            mem_full   <= 1'b0;
            old_mem    <= 1'b0;
            alu_rd_q   <= 5'd0;
            alu_data_q <= 32'd0;
            mem_rd_q   <= 5'd0;
            mem_data_q <= 32'd0;
            we3        <= 1'b0;
            wa3        <= 5'd0;
            wd3        <= 32'd0;
        end else begin
            alu_full <= alu_full_n;
            mem_full <= mem_full_n;
            old_mem  <= old_mem_n;
            if (alu_load) begin
                alu_rd_q   <= alu_rd;
                alu_data_q <= alu_data;
            end
            if (mem_load) begin
                mem_rd_q   <= mem_rd;
                mem_data_q <= mem_data;
            end
            // Address and data hold their last values when nothing retires.
            if (grant_alu) begin
                we3 <= 1'b1;
                wa3 <= alu_rd_q;
                wd3 <= alu_data_q;
            end else if (grant_mem) begin
                we3 <= 1'b1;
                wa3 <= mem_rd_q;
                wd3 <= mem_data_q;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

    assign busy = alu_full || mem_full || we3;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: two instances (memory-wins and ALU-wins ties)
// checked against an acceptance-ordered queue model of the write-back stream.
module tb_regfile_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        use_tie0;

    logic        alu_valid_1, mem_valid_1, alu_valid_0, mem_valid_0;
    logic        alu_ready_1, mem_ready_1, we3_1, busy_1;
    logic        alu_ready_0, mem_ready_0, we3_0, busy_0;
    logic [4:0]  wa3_1, wa3_0;
    logic [31:0] wd3_1, wd3_0;

    logic        o_alu_ready, o_mem_ready, o_we3, o_busy;
    logic [4:0]  o_wa3;
    logic [31:0] o_wd3;

    int n_checks = 0;
    int n_fail = 0;

    // Model: pending results in retirement order, entry = {is_mem, rd, data}.
    logic [37:0] exp_q[$];
    logic        m_we3 = 1'b0;
    logic [4:0]  m_wa3 = 5'd0;
    logic [31:0] m_wd3 = 32'd0;

    always #5 clk = ~clk;

    assign alu_valid_1 = alu_valid & ~use_tie0;
    assign mem_valid_1 = mem_valid & ~use_tie0;
    assign alu_valid_0 = alu_valid & use_tie0;
    assign mem_valid_0 = mem_valid & use_tie0;

    assign o_alu_ready = use_tie0 ? alu_ready_0 : alu_ready_1;
    assign o_mem_ready = use_tie0 ? mem_ready_0 : mem_ready_1;
    assign o_we3       = use_tie0 ? we3_0 : we3_1;
    assign o_wa3       = use_tie0 ? wa3_0 : wa3_1;
    assign o_wd3       = use_tie0 ? wd3_0 : wd3_1;
    assign o_busy      = use_tie0 ? busy_0 : busy_1;

    regfile_wb_arb #(.MEM_WINS_TIE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid_1), .alu_ready(alu_ready_1), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid_1), .mem_ready(mem_ready_1), .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3_1), .wa3(wa3_1), .wd3(wd3_1), .busy(busy_1)
    );

    regfile_wb_arb #(.MEM_WINS_TIE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid_0), .alu_ready(alu_ready_0), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid_0), .mem_ready(mem_ready_0), .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3_0), .wa3(wa3_0), .wd3(wd3_0), .busy(busy_0)
    );

    // A source may offer only if it has nothing pending, or its entry is next out.
    function automatic bit model_ready(input bit is_mem);
        bit holds = 1'b0;
        foreach (exp_q[i]) if (exp_q[i][37] == is_mem) holds = 1'b1;
        if (!holds) return 1'b1;
        return exp_q[0][37] == is_mem;
    endfunction

    function automatic bit model_busy();
        return (exp_q.size() != 0) || m_we3;
    endfunction

    // Advance one clock from a falling edge to the next, updating the model.
    task automatic step();
        bit ar, mr, aa, ma, tie_mem;
        logic [37:0] e;
        ar = model_ready(1'b0);
        mr = model_ready(1'b1);
        tie_mem = !use_tie0;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_we3 = 1'b0;
            m_wa3 = 5'd0;
            m_wd3 = 32'd0;
        end else begin
            aa = alu_valid && ar && (alu_rd != 5'd0);
            ma = mem_valid && mr && (mem_rd != 5'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_we3 = 1'b1;
                m_wa3 = e[36:32];
                m_wd3 = e[31:0];
            end else begin
                m_we3 = 1'b0;
            end
            if (aa && ma && tie_mem) begin
                exp_q.push_back({1'b1, mem_rd, mem_data});
                exp_q.push_back({1'b0, alu_rd, alu_data});
            end else begin
                if (aa) exp_q.push_back({1'b0, alu_rd, alu_data});
                if (ma) exp_q.push_back({1'b1, mem_rd, mem_data});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd7;
        alu_data = $urandom;
        step();
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %0h expected 0", o_we3); end
        n_checks++; if (o_wa3 !== 5'd0) begin n_fail++; $display("FAIL reset_wa3: got %0h expected 0", o_wa3); end
        n_checks++; if (o_wd3 !== 32'd0) begin n_fail++; $display("FAIL reset_wd3: got %0h expected 0", o_wd3); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", o_busy); end
        rst_n = 1'b1;
        alu_valid = 1'b0;
        n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready: got %0h expected 1", o_alu_ready); end
        n_checks++; if (o_mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready: got %0h expected 1", o_mem_ready); end
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: got %0h expected 0", o_we3); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0h expected 0", o_busy); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1;
        alu_rd = 5'd5;
        alu_data = 32'h1234_5678;
        n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0h expected 1", o_alu_ready); end
        step();
        alu_valid = 1'b0;
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL single_we3_k: got %0h expected 0", o_we3); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_k: got %0h expected 1", o_busy); end
        step();
        n_checks++; if (o_we3 !== 1'b1) begin n_fail++; $display("FAIL single_we3: got %0h expected 1", o_we3); end
        n_checks++; if (o_wa3 !== 5'd5) begin n_fail++; $display("FAIL single_wa3: got %0h expected 5", o_wa3); end
        n_checks++; if (o_wd3 !== 32'h1234_5678) begin n_fail++; $display("FAIL single_wd3: got %0h expected 12345678", o_wd3); end
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL single_we3_pulse: got %0h expected 0", o_we3); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0h expected 0", o_busy); end
    endtask

    task automatic test_tie();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hBBBB_0002;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA_0001;
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        n_checks++; if (o_alu_ready !== 1'b0) begin n_fail++; $display("FAIL tie_alu_ready: got %0h expected 0", o_alu_ready); end
        n_checks++; if (o_mem_ready !== 1'b1) begin n_fail++; $display("FAIL tie_mem_ready: got %0h expected 1", o_mem_ready); end
        step();
        n_checks++; if (o_we3 !== 1'b1) begin n_fail++; $display("FAIL tie_we3_1: got %0h expected 1", o_we3); end
        n_checks++; if (o_wa3 !== 5'd3) begin n_fail++; $display("FAIL tie_wa3_1: got %0h expected 3", o_wa3); end
        n_checks++; if (o_wd3 !== 32'hAAAA_0001) begin n_fail++; $display("FAIL tie_wd3_1: got %0h expected aaaa0001", o_wd3); end
        step();
        n_checks++; if (o_we3 !== 1'b1) begin n_fail++; $display("FAIL tie_we3_2: got %0h expected 1", o_we3); end
        n_checks++; if (o_wd3 !== 32'hBBBB_0002) begin n_fail++; $display("FAIL tie_wd3_2: got %0h expected bbbb0002", o_wd3); end
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL tie_idle: got %0h expected 0", o_we3); end
    endtask

    task automatic test_x0_drop();
        alu_valid = 1'b1;
        alu_rd = 5'd0;
        alu_data = 32'hFFFF_FFFF;
        n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0h expected 1", o_alu_ready); end
        step();
        alu_valid = 1'b0;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy_k: got %0h expected 0", o_busy); end
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL x0_we3: got %0h expected 0", o_we3); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %0h expected 0", o_busy); end
    endtask

    task automatic test_stream();
        int a_cnt = 0;
        int m_cnt = 0;
        int writes = 0;
        bit ar, mr;
        for (int i = 0; i < 20; i++) begin
            alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_data = 32'hA000_0000 + 32'(a_cnt);
            mem_valid = 1'b1; mem_rd = 5'($urandom_range(1, 31)); mem_data = 32'hB000_0000 + 32'(m_cnt);
            ar = model_ready(1'b0);
            mr = model_ready(1'b1);
            n_checks++; if (o_alu_ready !== ar) begin n_fail++; $display("FAIL stream_alu_ready[%0d]: got %0h expected %0h", i, o_alu_ready, ar); end
            n_checks++; if (o_mem_ready !== mr) begin n_fail++; $display("FAIL stream_mem_ready[%0d]: got %0h expected %0h", i, o_mem_ready, mr); end
            step();
            if (ar) a_cnt++;
            if (mr) m_cnt++;
            if (o_we3 === 1'b1) writes++;
            n_checks++; if (o_we3 !== m_we3) begin n_fail++; $display("FAIL stream_we3[%0d]: got %0h expected %0h", i, o_we3, m_we3); end
            n_checks++; if (o_wa3 !== m_wa3) begin n_fail++; $display("FAIL stream_wa3[%0d]: got %0h expected %0h", i, o_wa3, m_wa3); end
            n_checks++; if (o_wd3 !== m_wd3) begin n_fail++; $display("FAIL stream_wd3[%0d]: got %0h expected %0h", i, o_wd3, m_wd3); end
            if (i > 0) begin
                n_checks++; if (o_we3 !== 1'b1) begin n_fail++; $display("FAIL stream_full_rate[%0d]: got %0h expected 1", i, o_we3); end
            end
        end
        n_checks++;
        if (writes != a_cnt + m_cnt - exp_q.size()) begin
            n_fail++; $display("FAIL stream_count: got %0d expected %0d", writes, a_cnt + m_cnt - exp_q.size());
        end
        rst_n = 1'b0;
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL stream_rst_we3: got %0h expected 0", o_we3); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL stream_rst_busy: got %0h expected 0", o_busy); end
        n_checks++; if (o_wd3 !== 32'd0) begin n_fail++; $display("FAIL stream_rst_wd3: got %0h expected 0", o_wd3); end
        rst_n = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL stream_rst_alu_ready: got %0h expected 1", o_alu_ready); end
        n_checks++; if (o_mem_ready !== 1'b1) begin n_fail++; $display("FAIL stream_rst_mem_ready: got %0h expected 1", o_mem_ready); end
        step();
        n_checks++; if (o_we3 !== 1'b0) begin n_fail++; $display("FAIL stream_no_partial: got %0h expected 0", o_we3); end
    endtask

    task automatic test_age();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1111_1111;
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h2222_2222;
        step();
        mem_valid = 1'b0;
        n_checks++; if (o_wd3 !== 32'h1111_1111) begin n_fail++; $display("FAIL age_alu_first: got %0h expected 11111111", o_wd3); end
        step();
        n_checks++; if (o_wd3 !== 32'h2222_2222) begin n_fail++; $display("FAIL age_mem_second: got %0h expected 22222222", o_wd3); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        use_tie0 = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h3333_3333;
        step();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h4444_4444;
        step();
        alu_valid = 1'b0;
        n_checks++; if (o_wa3 !== 5'd12) begin n_fail++; $display("FAIL age_tie0_wa3: got %0h expected c", o_wa3); end
        n_checks++; if (o_wd3 !== 32'h3333_3333) begin n_fail++; $display("FAIL age_mem_first: got %0h expected 33333333", o_wd3); end
        step();
        n_checks++; if (o_wd3 !== 32'h4444_4444) begin n_fail++; $display("FAIL age_alu_second: got %0h expected 44444444", o_wd3); end
        step();
    endtask

    task automatic test_random(input bit tie0);
        bit ar, mr;
        use_tie0 = tie0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 155; i++) begin
            alu_valid = (i < 150) && ($urandom_range(0, 3) != 0);
            alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data = $urandom;
            mem_valid = (i < 150) && ($urandom_range(0, 3) != 0);
            mem_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem_data = $urandom;
            ar = model_ready(1'b0);
            mr = model_ready(1'b1);
            n_checks++; if (o_alu_ready !== ar) begin n_fail++; $display("FAIL rand%0d_alu_ready[%0d]: got %0h expected %0h", tie0, i, o_alu_ready, ar); end
            n_checks++; if (o_mem_ready !== mr) begin n_fail++; $display("FAIL rand%0d_mem_ready[%0d]: got %0h expected %0h", tie0, i, o_mem_ready, mr); end
            step();
            n_checks++; if (o_we3 !== m_we3) begin n_fail++; $display("FAIL rand%0d_we3[%0d]: got %0h expected %0h", tie0, i, o_we3, m_we3); end
            n_checks++; if (o_wa3 !== m_wa3) begin n_fail++; $display("FAIL rand%0d_wa3[%0d]: got %0h expected %0h", tie0, i, o_wa3, m_wa3); end
            n_checks++; if (o_wd3 !== m_wd3) begin n_fail++; $display("FAIL rand%0d_wd3[%0d]: got %0h expected %0h", tie0, i, o_wd3, m_wd3); end
            n_checks++; if (o_busy !== model_busy()) begin n_fail++; $display("FAIL rand%0d_busy[%0d]: got %0h expected %0h", tie0, i, o_busy, model_busy()); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        use_tie0 = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_tie();
        test_x0_drop();
        test_stream();
        test_age();
        test_random(1'b0);
        test_random(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
